// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: holds Stall for LATENCY cycles per access, strobes Done, traps illegal requests.
// Optional DMEM_LAST_READ_BYPASS_EN adds a one-entry last-read buffer that completes matching reads in zero cycles.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        Createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Busy,
  output logic        err
);

  // state    | meaning
  // S_IDLE   | waiting for a request
  // S_ACCESS | latched request in flight, counting down
  // S_DONE   | one-cycle completion strobe
  // S_HALTED | dump requested, ignores everything until reset
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  is_wr_q, is_wr_d;
  logic [15:0]           dataout_q, dataout_d;
  logic                  err_q, err_d;
  logic [15:0]           mem_q [WORDS];

  logic                  req_any;
  logic                  req_legal;
  logic [DEPTH_LOG2-1:0] in_idx;
  logic                  bypass_hit;
  logic                  stall_c;
  logic                  done_c;

  logic                  acc_en;
  logic                  acc_wr;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [15:0]           acc_wdata;
  logic [15:0]           rd_word;

  assign req_any   = Rd | Wr;
  assign req_legal = (Rd ^ Wr) & ~Addr[0];
  assign in_idx    = Addr[DEPTH_LOG2:1];

  generate
    if (DEPTH_LOG2 < 15) begin : g_unused_addr
      logic unused_addr_hi;
      assign unused_addr_hi = ^Addr[15:DEPTH_LOG2+1];
    end
  endgenerate

  // The array is touched at exactly one edge per access: the acceptance edge
  // when LATENCY is 1, otherwise the last ACCESS edge using the latched copy.
  always_comb begin
    acc_en    = 1'b0;
    acc_wr    = is_wr_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE && !Createdump && req_legal && !bypass_hit && LATENCY == 1) begin
      acc_en    = 1'b1;
      acc_wr    = Wr;
      acc_idx   = in_idx;
      acc_wdata = DataIn;
    end else if (state_q == S_ACCESS && cnt_q == 4'd1) begin
      acc_en = 1'b1;
    end
  end

  assign rd_word = mem_q[acc_idx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    dataout_d = dataout_q;
    err_d     = err_q;
    stall_c   = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Createdump) begin
          state_d = S_HALTED;
        end else if (bypass_hit) begin
          done_c    = 1'b1;
          dataout_d = DataOut;
        end else if (req_legal) begin
          stall_c = 1'b1;
          idx_d   = in_idx;
          wdata_d = DataIn;
          is_wr_d = Wr;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? S_DONE : S_ACCESS;
        end else if (req_any) begin
          err_d = 1'b1;
        end
      end
      S_ACCESS: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
    if (acc_en && !acc_wr) dataout_d = rd_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= 16'd0;
      is_wr_q   <= 1'b0;
      dataout_q <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      dataout_q <= dataout_d;
      err_q     <= err_d;
    end
  end

  // No reset on the array; gating with rst drops a write pending at the reset edge.
  always_ff @(posedge clk) begin
    if (rst && acc_en && acc_wr) mem_q[acc_idx] <= acc_wdata;
  end

`ifdef DMEM_LAST_READ_BYPASS_EN
  logic                  buf_valid_q, buf_valid_d;
  logic [DEPTH_LOG2-1:0] buf_idx_q, buf_idx_d;
  logic [15:0]           buf_data_q, buf_data_d;

  assign bypass_hit = (state_q == S_IDLE) && !Createdump && Rd && !Wr && !Addr[0] &&
                      buf_valid_q && (buf_idx_q == in_idx);

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
    buf_data_d  = buf_data_q;
    if (acc_en && !acc_wr) begin
      buf_valid_d = 1'b1;
      buf_idx_d   = acc_idx;
      buf_data_d  = rd_word;
    end else if (acc_en && acc_wr && buf_valid_q && buf_idx_q == acc_idx) begin
      buf_data_d = acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_data_q  <= 16'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_idx_q   <= buf_idx_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign DataOut = bypass_hit ? buf_data_q : dataout_q;
`else
  assign bypass_hit = 1'b0;
  assign DataOut    = dataout_q;
`endif

  assign Stall = stall_c & rst;
  assign Done  = done_c & rst;
  assign Busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus random bench for dmem_responder with LATENCY=4 and LATENCY=1 instances side by side.
// Expected values come from a word-array model and the request timing rules.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr [2];
  logic [15:0] din  [2];
  logic        rd   [2];
  logic        wr   [2];
  logic        cdump[2];
  logic [15:0] dout [2];
  logic        done [2];
  logic        stall[2];
  logic        busy [2];
  logic        err  [2];

  int          errors = 0;
  int          checks = 0;
  int          lat [2] = '{4, 1};
  logic [15:0] model_mem [2][1024];
  logic [15:0] dout_exp [2];
  logic        err_exp  [2];

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst_n), .Addr(addr[0]), .DataIn(din[0]), .Rd(rd[0]), .Wr(wr[0]),
    .Createdump(cdump[0]), .DataOut(dout[0]), .Done(done[0]), .Stall(stall[0]),
    .Busy(busy[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .Addr(addr[1]), .DataIn(din[1]), .Rd(rd[1]), .Wr(wr[1]),
    .Createdump(cdump[1]), .DataOut(dout[1]), .Done(done[1]), .Stall(stall[1]),
    .Busy(busy[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      err_exp[d]  = 1'b0;
      dout_exp[d] = 16'd0;
    end
  endtask

  // Starts and ends at posedge+1; the request stays asserted through the Done cycle.
  task automatic access(input int d, input bit is_wr, input logic [15:0] a,
                        input logic [15:0] data, input string tag);
    int n;
    logic [15:0] exp_rd;
    exp_rd = model_mem[d][a[10:1]];
    addr[d] = a;
    din[d]  = data;
    rd[d]   = !is_wr;
    wr[d]   = is_wr;
    n = 0;
    @(negedge clk);
    while (stall[d] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("%s_stall_cycles", tag), 16'(n), 16'(lat[d]));
    chk($sformatf("%s_done", tag), 16'(done[d]), 16'd1);
    if (is_wr) begin
      model_mem[d][a[10:1]] = data;
      chk($sformatf("%s_dout_held", tag), dout[d], dout_exp[d]);
    end else begin
      dout_exp[d] = exp_rd;
      chk($sformatf("%s_rdata", tag), dout[d], exp_rd);
    end
    next_cycle();
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  task automatic illegal(input int d, input bit r, input bit w, input logic [15:0] a, input string tag);
    addr[d] = a;
    din[d]  = 16'h0BAD;
    rd[d]   = r;
    wr[d]   = w;
    @(negedge clk);
    chk($sformatf("%s_stall", tag), 16'(stall[d]), 16'd0);
    next_cycle();
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    err_exp[d] = 1'b1;
    @(negedge clk);
    chk($sformatf("%s_err", tag), 16'(err[d]), 16'd1);
    chk($sformatf("%s_busy", tag), 16'(busy[d]), 16'd0);
    next_cycle();
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] v;
    int          r;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = 16'd0; din[d] = 16'd0; rd[d] = 1'b0; wr[d] = 1'b0; cdump[d] = 1'b0;
      err_exp[d] = 1'b0; dout_exp[d] = 16'd0;
    end

    // Reset with a legal read presented: Stall must stay low
    rd[0] = 1'b1; addr[0] = 16'h0030;
    @(negedge clk);
    chk("stall_during_reset", 16'(stall[0]), 16'd0);
    rd[0] = 1'b0;
    do_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_busy%0d", d),  16'(busy[d]),  16'd0);
      chk($sformatf("rst_stall%0d", d), 16'(stall[d]), 16'd0);
      chk($sformatf("rst_done%0d", d),  16'(done[d]),  16'd0);
      chk($sformatf("rst_err%0d", d),   16'(err[d]),   16'd0);
      chk($sformatf("rst_dout%0d", d),  dout[d],       16'd0);
    end
    next_cycle();

    // Write then read back on LATENCY=4
    access(0, 1'b1, 16'h0010, 16'hBEEF, "wr_beef");
    @(negedge clk);
    chk("busy_after_write", 16'(busy[0]), 16'd0);
    next_cycle();
    access(0, 1'b0, 16'h0010, 16'h0000, "rd_beef");
    access(0, 1'b0, 16'h0010, 16'h0000, "rd_beef_again");

    // Illegal Rd&Wr leaves the array untouched, err sticks
    illegal(0, 1'b1, 1'b1, 16'h0010, "ill_rdwr");
    access(0, 1'b0, 16'h0010, 16'h0000, "rd_after_ill");
    @(negedge clk);
    chk("err_sticky", 16'(err[0]), 16'd1);
    next_cycle();
    do_reset();
    @(negedge clk);
    chk("err_cleared", 16'(err[0]), 16'd0);
    next_cycle();
    illegal(0, 1'b1, 1'b0, 16'h0011, "ill_odd");

    // Reset in the second Stall cycle discards the write
    access(0, 1'b1, 16'h0020, 16'h5A5A, "wr_pre");
    addr[0] = 16'h0020; din[0] = 16'h1234; wr[0] = 1'b1;
    @(negedge clk);
    chk("mid_stall1", 16'(stall[0]), 16'd1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_stall_forced", 16'(stall[0]), 16'd0);
    next_cycle();
    rst_n = 1'b1;
    wr[0] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      err_exp[d] = 1'b0; dout_exp[d] = 16'd0;
    end
    @(negedge clk);
    chk("mid_after_stall", 16'(stall[0]), 16'd0);
    chk("mid_after_busy", 16'(busy[0]), 16'd0);
    next_cycle();
    access(0, 1'b0, 16'h0020, 16'h0000, "rd_pre");

    // Back-to-back on LATENCY=1
    access(1, 1'b1, 16'h0002, 16'(($urandom)), "b2b_wr2");
    access(1, 1'b1, 16'h0004, 16'(($urandom)), "b2b_wr4");
    access(1, 1'b0, 16'h0002, 16'h0000, "b2b_rd2");
    access(1, 1'b0, 16'h0004, 16'h0000, "b2b_rd4");

    // Random traffic against the word-array model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++)
        access(d, 1'b1, 16'h0040 + 16'(2 * i), 16'($urandom), $sformatf("rnd_init%0d_%0d", d, i));
      for (int i = 0; i < 30; i++) begin
        r = int'($urandom_range(0, 9));
        a = 16'h0040 + 16'(2 * $urandom_range(0, 7));
        v = 16'($urandom);
        if (r < 4)
          access(d, 1'b1, a, v, $sformatf("rnd_wr%0d_%0d", d, i));
        else if (r < 8)
          access(d, 1'b0, a, 16'h0000, $sformatf("rnd_rd%0d_%0d", d, i));
        else if (r == 8)
          illegal(d, 1'b1, 1'b1, a, $sformatf("rnd_ill2_%0d_%0d", d, i));
        else
          illegal(d, v[0], ~v[0], a | 16'h0001, $sformatf("rnd_illodd%0d_%0d", d, i));
      end
      @(negedge clk);
      chk($sformatf("rnd_err%0d", d), 16'(err[d]), 16'(err_exp[d]));
      next_cycle();
    end

    // Createdump with a read pending halts; later writes are ignored
    cdump[0] = 1'b1; rd[0] = 1'b1; addr[0] = 16'h0010;
    next_cycle();
    cdump[0] = 1'b0; rd[0] = 1'b0;
    @(negedge clk);
    chk("halt_busy", 16'(busy[0]), 16'd1);
    chk("halt_stall", 16'(stall[0]), 16'd0);
    chk("halt_done", 16'(done[0]), 16'd0);
    next_cycle();
    wr[0] = 1'b1; addr[0] = 16'h0010; din[0] = 16'hDEAD;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("halt_wr_stall%0d", i), 16'(stall[0]), 16'd0);
      chk($sformatf("halt_wr_done%0d", i), 16'(done[0]), 16'd0);
      chk($sformatf("halt_wr_busy%0d", i), 16'(busy[0]), 16'd1);
      next_cycle();
    end
    wr[0] = 1'b0;
    do_reset();
    access(0, 1'b0, 16'h0010, 16'h0000, "rd_after_halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
